shift_seq: RTL and testbench

- Multi-cycle variable-amount shift controller for the MIPS ALU shift path (SLL/SRL/SRA, shamt 0..31).
- Builds a variable shift by repeatedly applying a fixed-distance shift stage (distance STEP) plus a 1-bit stage to an internal 32-bit accumulator.
- Sits beside the ALU and uses a start/done handshake; the core stalls on busy.

---
 rtl/shift_seq_if.sv | 31 +++
 rtl/shift_seq.sv | 107 ++++++++++
 tb/tb_shift_seq.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/shift_seq_if.sv
// Handshake and data bundle between the core-side requester and the
// multi-cycle shift controller.
interface shift_seq_if;
  logic        start;
  logic [1:0]  op;
  logic [4:0]  shamt;
  logic [31:0] data_in;
  logic [31:0] result;
  logic        busy;
  logic        done;

  modport master (
    output start,
    output op,
    output shamt,
    output data_in,
    input  result,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  op,
    input  shamt,
    input  data_in,
    output result,
    output busy,
    output done
  );
endinterface

// File: rtl/shift_seq.sv
// Multi-cycle variable-amount shifter for the ALU shift path.
// A variable shift is built from repeated coarse shifts of STEP bits plus
// single-bit shifts, applied to a 32-bit accumulator that is also the result.
module shift_seq #(
  parameter int STEP = 2
) (
  input logic       clk,
  input logic       rst,
  shift_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [4:0] STEP_AMT = 5'(STEP);

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_BAD = 2'b11;

  state_t      state;
  state_t      state_next;
  logic [31:0] acc;
  logic [31:0] acc_next;
  logic [4:0]  rem;
  logic [4:0]  rem_next;
  logic [1:0]  op_r;
  logic [1:0]  op_next;
  logic        accept;

  // One shift step: either the coarse STEP distance or a single bit.
  // SRA refills from the current bit 31, so the sign survives every step.
  function automatic logic [31:0] shift_step(input logic [31:0] v,
                                             input logic [1:0]  o,
                                             input logic        coarse);
    logic [31:0] r;
    r = v;
    case (o)
      OP_SRL:  r = coarse ? (v >> STEP) : (v >> 1);
      OP_SLL:  r = coarse ? (v << STEP) : (v << 1);
      OP_SRA:  r = coarse ? $unsigned($signed(v) >>> STEP)
                          : $unsigned($signed(v) >>> 1);
      default: r = v;
    endcase
    return r;
  endfunction

  // A new request is taken only when no shift is in flight.
  assign accept = bus.start && ((state == IDLE) || (state == DONE));

  // Next-state and datapath update: load on accept, iterate in SHIFT,
  // and leave DONE for IDLE when nobody asks for another shift.
  always_comb begin
    state_next = state;
    acc_next   = acc;
    rem_next   = rem;
    op_next    = op_r;
    if (accept) begin
      op_next  = bus.op;
      acc_next = (bus.op == OP_BAD) ? 32'd0 : bus.data_in;
      rem_next = bus.shamt;
      state_next = ((bus.shamt == 5'd0) || (bus.op == OP_BAD)) ? DONE : SHIFT;
    end else begin
      case (state)
        SHIFT: begin
          if (rem >= STEP_AMT) begin
            acc_next = shift_step(acc, op_r, 1'b1);
            rem_next = rem - STEP_AMT;
          end else begin
            acc_next = shift_step(acc, op_r, 1'b0);
            rem_next = rem - 5'd1;
          end
          if (rem_next == 5'd0) begin
            state_next = DONE;
          end
        end
        DONE:    state_next = IDLE;
        IDLE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // State and datapath registers; reset discards any shift in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= 32'd0;
      rem   <= 5'd0;
      op_r  <= OP_SRL;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      rem   <= rem_next;
      op_r  <= op_next;
    end
  end

  assign bus.result = acc;
  assign bus.busy   = (state == SHIFT);
  assign bus.done   = (state == DONE);

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq: directed cases from the shifter's
// corner behaviour followed by randomized requests, all judged against a
// one-shot arithmetic reference of the shift and its cycle cost.
module tb_shift_seq;

  localparam int STEP = 2;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  shift_seq_if ifc ();

  shift_seq #(.STEP(STEP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference result: the whole shift done in one arithmetic operation.
  function automatic logic [31:0] model_result(input logic [1:0] o,
                                               input logic [4:0] sh,
                                               input logic [31:0] d);
    logic [31:0] r;
    case (o)
      2'b00:   r = d >> sh;
      2'b01:   r = d << sh;
      2'b10:   r = $unsigned($signed(d) >>> sh);
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Reference number of busy cycles for a request.
  function automatic int model_cycles(input logic [1:0] o, input logic [4:0] sh);
    int n;
    int s;
    s = int'(sh);
    if ((s == 0) || (o == 2'b11)) n = 0;
    else n = (s / STEP) + (s % STEP);
    return n;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request and let it be sampled on the next rising edge;
  // returns at #1 after that edge, i.e. inside the first cycle after accept.
  task automatic apply_stimulus(input logic [1:0] o, input logic [4:0] sh,
                                input logic [31:0] d);
    ifc.start   = 1'b1;
    ifc.op      = o;
    ifc.shamt   = sh;
    ifc.data_in = d;
    @(posedge clk);
    #1;
    ifc.start   = 1'b0;
    ifc.data_in = $urandom;
    ifc.shamt   = 5'($urandom_range(0, 31));
  endtask

  // Follow a request to its done pulse (bounded), checking busy while
  // waiting, then the cycle count and final result in the done cycle.
  task automatic wait_done(input string tag, input int exp_cyc,
                           input logic [31:0] exp_res);
    int cnt;
    cnt = 0;
    while ((ifc.done !== 1'b1) && (cnt < 40)) begin
      check_output({tag, "_busy"}, 32'(ifc.busy), 32'd1);
      cnt++;
      @(posedge clk);
      #1;
    end
    check_output({tag, "_done"}, 32'(ifc.done), 32'd1);
    check_output({tag, "_cycles"}, 32'(cnt), 32'(exp_cyc));
    check_output({tag, "_result"}, ifc.result, exp_res);
    check_output({tag, "_busy_in_done"}, 32'(ifc.busy), 32'd0);
  endtask

  // One cycle after done with no new request: idle, result held.
  task automatic check_hold(input string tag, input logic [31:0] exp_res);
    @(posedge clk);
    #1;
    check_output({tag, "_hold_done"}, 32'(ifc.done), 32'd0);
    check_output({tag, "_hold_busy"}, 32'(ifc.busy), 32'd0);
    check_output({tag, "_hold_result"}, ifc.result, exp_res);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o,
                        input logic [4:0] sh, input logic [31:0] d);
    apply_stimulus(o, sh, d);
    wait_done(tag, model_cycles(o, sh), model_result(o, sh, d));
  endtask

  // Directed steps followed by a randomized run.
  initial begin
    logic [1:0]  o;
    logic [4:0]  sh;
    logic [31:0] d;
    compared   = 0;
    mismatched = 0;
    rst         = 1'b1;
    ifc.start   = 1'b0;
    ifc.op      = 2'b00;
    ifc.shamt   = 5'd0;
    ifc.data_in = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_result", ifc.result, 32'd0);
    check_output("reset_busy", 32'(ifc.busy), 32'd0);
    check_output("reset_done", 32'(ifc.done), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] directed cases");
    run_op("srl5", 2'b00, 5'd5, 32'hF000_0000);
    check_output("srl5_const", ifc.result, 32'h0780_0000);
    check_hold("srl5", 32'h0780_0000);

    run_op("sra31_neg", 2'b10, 5'd31, 32'h8000_0000);
    check_output("sra31_neg_const", ifc.result, 32'hFFFF_FFFF);
    check_hold("sra31_neg", 32'hFFFF_FFFF);

    run_op("sra31_pos", 2'b10, 5'd31, 32'h7FFF_FFFF);
    check_hold("sra31_pos", 32'h0000_0000);

    run_op("sll0", 2'b01, 5'd0, 32'h0000_0001);
    check_hold("sll0", 32'h0000_0001);
    run_op("sll1", 2'b01, 5'd1, 32'h0000_0001);
    check_hold("sll1", 32'h0000_0002);
    run_op("sll31", 2'b01, 5'd31, 32'h0000_0001);
    check_hold("sll31", 32'h8000_0000);

    run_op("bad_op", 2'b11, 5'd7, 32'hDEAD_BEEF);
    check_hold("bad_op", 32'h0000_0000);

    // A request raised during a shift must not disturb it.
    apply_stimulus(2'b00, 5'd20, 32'hF0F0_1234);
    ifc.start   = 1'b1;
    ifc.op      = 2'b01;
    ifc.shamt   = 5'd3;
    ifc.data_in = 32'h0000_AAAA;
    repeat (2) begin
      check_output("ignore_busy", 32'(ifc.busy), 32'd1);
      @(posedge clk);
      #1;
    end
    ifc.start = 1'b0;
    wait_done("ignore", model_cycles(2'b00, 5'd20) - 2,
              model_result(2'b00, 5'd20, 32'hF0F0_1234));
    check_hold("ignore", model_result(2'b00, 5'd20, 32'hF0F0_1234));

    // Back-to-back: new request accepted in the done cycle.
    run_op("b2b_first", 2'b00, 5'd3, 32'h0000_0F00);
    run_op("b2b_second", 2'b01, 5'd4, 32'h0000_0001);
    check_output("b2b_second_const", ifc.result, 32'h0000_0010);
    check_hold("b2b", 32'h0000_0010);

    // Reset in the third busy cycle discards the shift with no done.
    apply_stimulus(2'b00, 5'd20, 32'h1234_5678);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check_output("rst_mid_busy_before", 32'(ifc.busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_output("rst_mid_result", ifc.result, 32'd0);
    check_output("rst_mid_busy", 32'(ifc.busy), 32'd0);
    check_output("rst_mid_done", 32'(ifc.done), 32'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check_output("rst_mid_no_done", 32'(ifc.done), 32'd0);
    end
    run_op("after_rst", 2'b10, 5'd9, 32'h8765_4321);
    check_hold("after_rst", model_result(2'b10, 5'd9, 32'h8765_4321));

    $display("[TB] randomized cases");
    for (int i = 0; i < 60; i++) begin
      o  = 2'($urandom_range(0, 3));
      sh = 5'($urandom_range(0, 31));
      d  = $urandom;
      run_op("rand", o, sh, d);
      if ($urandom_range(0, 1) == 0) begin
        check_hold("rand", model_result(o, sh, d));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
